kyber_bram_sequencer: RTL and testbench

KYBER_BRAM_SEQUENCER -- requirements
Module: kyber_bram_sequencer

---
 rtl/kyber_bram_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_kyber_bram_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kyber_bram_sequencer.sv
// Kyber BRAM sequencer: loads a mode-dependent segment of port-B BRAM into the
// core input buffer, pulses the core start, waits for completion, then writes
// the core output words back to a mode-dependent store segment.
module kyber_bram_sequencer #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 128
) (
   input  logic              s_axi_aclk,
   input  logic              s_axi_aresetn,
   input  logic              start,
   input  logic [1:0]        mode,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              bram_en,
   output logic              bram_we,
   output logic [DATA_W-1:0] bram_wrdata,
   input  logic [DATA_W-1:0] bram_rddata,
   output logic              ld_valid,
   output logic [6:0]        ld_idx,
   output logic [DATA_W-1:0] ld_data,
   output logic              core_start,
   input  logic              core_finish,
   output logic [6:0]        st_idx,
   input  logic [DATA_W-1:0] st_data
);

   typedef enum logic [2:0] {
      StIdle, StLoad, StLdrain, StRun, StWait, StStore, StDone
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [6:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              en_q, en_d;
   logic              we_q, we_d;
   logic              ld_valid_q, ld_valid_d;
   logic [6:0]        ld_idx_q, ld_idx_d;
   logic [6:0]        st_idx_q, st_idx_d;
   logic              core_start_q, core_start_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;

   logic [1:0]        sel_mode;
   logic [ADDR_W-1:0] ld_base, st_base;
   logic [6:0]        ld_cnt, st_cnt;

   // Segment table; IDLE looks at the live mode so the first read issues on acceptance
   always_comb begin
      sel_mode = (state_q == StIdle) ? mode : mode_q;
      ld_base  = '0;
      ld_cnt   = '0;
      st_base  = '0;
      st_cnt   = '0;
      case (sel_mode)
         2'd0: begin
            ld_base = ADDR_W'(0);
            ld_cnt  = 7'd0;
            st_base = ADDR_W'(128);
            st_cnt  = 7'd98;
         end
         2'd1: begin
            ld_base = ADDR_W'(0);
            ld_cnt  = 7'd54;
            st_base = ADDR_W'(226);
            st_cnt  = 7'd2;
         end
         2'd2: begin
            ld_base = ADDR_W'(54);
            ld_cnt  = 7'd50;
            st_base = ADDR_W'(228);
            st_cnt  = 7'd2;
         end
         default: ;
      endcase
   end

   // Next-state and next-output computation; every output is registered
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      en_d         = 1'b0;
      we_d         = 1'b0;
      ld_valid_d   = 1'b0;
      ld_idx_d     = ld_idx_q;
      st_idx_d     = st_idx_q;
      core_start_d = 1'b0;
      done_d       = 1'b0;
      err_d        = err_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               if (mode == 2'd3) begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = StDone;
               end else begin
                  mode_d = mode;
                  err_d  = 1'b0;
                  if (ld_cnt == 7'd0) begin
                     core_start_d = 1'b1;
                     state_d      = StRun;
                  end else begin
                     cnt_d   = 7'd0;
                     addr_d  = ld_base;
                     en_d    = 1'b1;
                     state_d = StLoad;
                  end
               end
            end
         end
         StLoad: begin
            // Word cnt_q is being read now; its data shows up next cycle
            ld_valid_d = 1'b1;
            ld_idx_d   = cnt_q;
            if (cnt_q == ld_cnt - 7'd1) begin
               state_d = StLdrain;
            end else begin
               cnt_d  = cnt_q + 7'd1;
               addr_d = addr_q + ADDR_W'(1);
               en_d   = 1'b1;
            end
         end
         StLdrain: begin
            core_start_d = 1'b1;
            state_d      = StRun;
         end
         StRun: begin
            state_d = StWait;
         end
         StWait: begin
            if (core_finish) begin
               cnt_d    = 7'd0;
               st_idx_d = 7'd0;
               addr_d   = st_base;
               en_d     = 1'b1;
               we_d     = 1'b1;
               state_d  = StStore;
            end
         end
         StStore: begin
            if (cnt_q == st_cnt - 7'd1) begin
               done_d  = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d    = cnt_q + 7'd1;
               st_idx_d = cnt_q + 7'd1;
               addr_d   = addr_q + ADDR_W'(1);
               en_d     = 1'b1;
               we_d     = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   // State and registered outputs; reset aborts any transfer immediately
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_q      <= StIdle;
         mode_q       <= 2'd0;
         cnt_q        <= 7'd0;
         addr_q       <= '0;
         en_q         <= 1'b0;
         we_q         <= 1'b0;
         ld_valid_q   <= 1'b0;
         ld_idx_q     <= 7'd0;
         st_idx_q     <= 7'd0;
         core_start_q <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         en_q         <= en_d;
         we_q         <= we_d;
         ld_valid_q   <= ld_valid_d;
         ld_idx_q     <= ld_idx_d;
         st_idx_q     <= st_idx_d;
         core_start_q <= core_start_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign bram_addr   = addr_q;
   assign bram_en     = en_q;
   assign bram_we     = we_q;
   // Write data follows the core output mux, which follows st_idx in the same cycle
   assign bram_wrdata = st_data;
   assign ld_valid    = ld_valid_q;
   assign ld_idx      = ld_idx_q;
   assign ld_data     = bram_rddata;
   assign core_start  = core_start_q;
   assign st_idx      = st_idx_q;

endmodule

// File: tb/tb_kyber_bram_sequencer.sv
// Testbench for kyber_bram_sequencer: cycle-by-cycle comparison against a
// timeline derived from the segment table and the latency rules.
module tb_kyber_bram_sequencer;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 128;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [1:0]        mode;
   logic              busy, done, err;
   logic [ADDR_W-1:0] bram_addr;
   logic              bram_en, bram_we;
   logic [DATA_W-1:0] bram_wrdata;
   logic [DATA_W-1:0] bram_rddata;
   logic              ld_valid;
   logic [6:0]        ld_idx;
   logic [DATA_W-1:0] ld_data;
   logic              core_start;
   logic              core_finish;
   logic [6:0]        st_idx;
   logic [DATA_W-1:0] st_data;

   logic [DATA_W-1:0] mem    [256];
   logic [DATA_W-1:0] st_tab [128];

   int lb_tab [4] = '{0, 0, 54, 0};
   int lc_tab [4] = '{0, 54, 50, 0};
   int sb_tab [4] = '{128, 226, 228, 0};
   int sc_tab [4] = '{98, 2, 2, 0};

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   kyber_bram_sequencer #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) dut (
      .s_axi_aclk   (clk),
      .s_axi_aresetn(rst_n),
      .start        (start),
      .mode         (mode),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .bram_addr    (bram_addr),
      .bram_en      (bram_en),
      .bram_we      (bram_we),
      .bram_wrdata  (bram_wrdata),
      .bram_rddata  (bram_rddata),
      .ld_valid     (ld_valid),
      .ld_idx       (ld_idx),
      .ld_data      (ld_data),
      .core_start   (core_start),
      .core_finish  (core_finish),
      .st_idx       (st_idx),
      .st_data      (st_data)
   );

   // BRAM port B read model with one cycle latency
   always @(posedge clk) begin
      if (bram_en && !bram_we) bram_rddata <= mem[bram_addr];
   end

   // Core output mux model
   assign st_data = st_tab[st_idx];

   function automatic logic [DATA_W-1:0] rand_word();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic fill(input bit ident);
      for (int i = 0; i < 256; i++) mem[i] = ident ? DATA_W'(i) : rand_word();
      for (int i = 0; i < 128; i++) st_tab[i] = rand_word();
   endtask

   // One command, checked every cycle against the expected timeline.
   // Called positioned just after a falling edge; returns likewise.
   task automatic run_op(input logic [1:0] m, input int delay, input bit inj,
                         input int abort_at);
      int lb, lc, sb, sc, cs, fin, st0, dn;
      bit exp_rd, exp_wr, exp_ld;
      logic [ADDR_W-1:0] ea;
      lb = lb_tab[m];
      lc = lc_tab[m];
      sb = sb_tab[m];
      sc = sc_tab[m];
      if (m == 2'd3) begin
         cs  = -100;
         fin = -100;
         st0 = -100;
         dn  = 1;
      end else begin
         cs  = (lc == 0) ? 1 : lc + 2;
         fin = cs + delay;
         st0 = fin + 1;
         dn  = st0 + sc;
      end
      start       = 1'b1;
      mode        = m;
      core_finish = 1'b0;
      for (int c = 1; c <= dn + 1; c++) begin
         @(negedge clk);
         exp_rd = (c <= lc);
         exp_wr = (c >= st0) && (c < st0 + sc);
         exp_ld = (c >= 2) && (c <= lc + 1);
         checks++;
         if (bram_en !== (exp_rd || exp_wr)) begin
            errors++;
            $display("FAIL bram_en m=%0d cyc=%0d: got %b want %b", m, c, bram_en, exp_rd || exp_wr);
         end
         checks++;
         if (bram_we !== exp_wr) begin
            errors++;
            $display("FAIL bram_we m=%0d cyc=%0d: got %b want %b", m, c, bram_we, exp_wr);
         end
         if (exp_rd) begin
            ea = ADDR_W'(lb + c - 1);
            checks++;
            if (bram_addr !== ea) begin
               errors++;
               $display("FAIL rd_addr m=%0d cyc=%0d: got %0d want %0d", m, c, bram_addr, ea);
            end
         end
         if (exp_wr) begin
            ea = ADDR_W'(sb + c - st0);
            checks++;
            if (bram_addr !== ea) begin
               errors++;
               $display("FAIL wr_addr m=%0d cyc=%0d: got %0d want %0d", m, c, bram_addr, ea);
            end
            checks++;
            if (st_idx !== 7'(c - st0)) begin
               errors++;
               $display("FAIL st_idx m=%0d cyc=%0d: got %0d want %0d", m, c, st_idx, c - st0);
            end
            checks++;
            if (bram_wrdata !== st_tab[c-st0]) begin
               errors++;
               $display("FAIL wrdata m=%0d cyc=%0d: got %h want %h", m, c, bram_wrdata,
                        st_tab[c-st0]);
            end
         end
         checks++;
         if (ld_valid !== exp_ld) begin
            errors++;
            $display("FAIL ld_valid m=%0d cyc=%0d: got %b want %b", m, c, ld_valid, exp_ld);
         end
         if (exp_ld) begin
            checks++;
            if (ld_idx !== 7'(c - 2)) begin
               errors++;
               $display("FAIL ld_idx m=%0d cyc=%0d: got %0d want %0d", m, c, ld_idx, c - 2);
            end
            checks++;
            if (ld_data !== mem[lb+c-2]) begin
               errors++;
               $display("FAIL ld_data m=%0d cyc=%0d: got %h want %h", m, c, ld_data,
                        mem[lb+c-2]);
            end
         end
         checks++;
         if (core_start !== (c == cs)) begin
            errors++;
            $display("FAIL core_start m=%0d cyc=%0d: got %b want %b", m, c, core_start, c == cs);
         end
         checks++;
         if (done !== (c == dn)) begin
            errors++;
            $display("FAIL done m=%0d cyc=%0d: got %b want %b", m, c, done, c == dn);
         end
         checks++;
         if (busy !== (c <= dn)) begin
            errors++;
            $display("FAIL busy m=%0d cyc=%0d: got %b want %b", m, c, busy, c <= dn);
         end
         checks++;
         if (err !== (m == 2'd3)) begin
            errors++;
            $display("FAIL err m=%0d cyc=%0d: got %b want %b", m, c, err, m == 2'd3);
         end
         if (c == abort_at) return;
         // Inputs for the next edge; mode wiggles freely while busy
         core_finish = (c == fin) || (inj && c == 5);
         start       = inj && (c == cs + 2);
         mode        = 2'($urandom_range(0, 3));
      end
      start       = 1'b0;
      core_finish = 1'b0;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      start       = 1'b0;
      mode        = 2'd0;
      core_finish = 1'b0;
      fill(1'b0);
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, err, bram_en, bram_we, ld_valid, core_start} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 0000000",
                  {busy, done, err, bram_en, bram_we, ld_valid, core_start});
      end
      checks++;
      if ({bram_addr, ld_idx, st_idx} !== '0) begin
         errors++;
         $display("FAIL reset_regs: got addr=%0d ld_idx=%0d st_idx=%0d want 0",
                  bram_addr, ld_idx, st_idx);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, bram_en} !== 2'b00) begin
         errors++;
         $display("FAIL idle_after_reset: got busy/en=%b want 00", {busy, bram_en});
      end
   endtask

   task automatic test_mode1();
      fill(1'b1);
      run_op(2'd1, 10, 1'b0, -1);
   endtask

   task automatic test_mode0();
      fill(1'b0);
      run_op(2'd0, 4, 1'b0, -1);
   endtask

   task automatic test_mode2();
      fill(1'b0);
      run_op(2'd2, 7, 1'b0, -1);
   endtask

   task automatic test_mode3_err();
      fill(1'b0);
      run_op(2'd3, 1, 1'b0, -1);
      run_op(2'd1, 3, 1'b0, -1);
   endtask

   task automatic test_ignored_inputs();
      fill(1'b0);
      run_op(2'd1, 6, 1'b1, -1);
      run_op(2'd2, 5, 1'b1, -1);
   endtask

   task automatic test_reset_mid_load();
      fill(1'b1);
      run_op(2'd1, 5, 1'b0, 21);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, err, bram_en, bram_we, ld_valid, core_start} !== 7'b0) begin
         errors++;
         $display("FAIL abort_flags: got %b want 0000000",
                  {busy, done, err, bram_en, bram_we, ld_valid, core_start});
      end
      checks++;
      if ({bram_addr, ld_idx, st_idx} !== '0) begin
         errors++;
         $display("FAIL abort_regs: got addr=%0d ld_idx=%0d st_idx=%0d want 0",
                  bram_addr, ld_idx, st_idx);
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({bram_en, busy} !== 2'b00) begin
            errors++;
            $display("FAIL abort_hold: got en/busy=%b want 00", {bram_en, busy});
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      run_op(2'd1, 2, 1'b0, -1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) begin
         fill(1'b0);
         run_op(2'($urandom_range(0, 3)), int'($urandom_range(1, 12)), 1'b0, -1);
      end
   endtask

   initial begin
      test_reset();
      test_mode1();
      test_mode0();
      test_mode2();
      test_mode3_err();
      test_ignored_inputs();
      test_reset_mid_load();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
